output_limit_buffer: RTL and testbench

- Single-clock output buffer between the application output FIFO read side (FWFT, IFCLK domain) and the high-speed Slave FIFO I/O block.
- Drains the output FIFO into an internal RAM buffer and presents a FWFT 16-bit stream to the I/O block.
- In limit mode, it releases only the number of words the host latched with reg_output_limit. The host reads that count over VCR before issuing a USB read of exactly that size.

---
 rtl/output_limit_buffer.sv | 138 +++++++++++++
 tb/tb_output_limit_buffer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_limit_buffer.sv
// Output buffer between the application FWFT FIFO and the Slave FIFO I/O block.
// Presents a FWFT 16-bit stream; in limit mode releases only the latched word count.
module output_limit_buffer #(
    parameter int unsigned ADDR_W    = 13,
    parameter logic [15:0] LIMIT_MAX = 16'hFFFF
) (
    input  logic        IFCLK,
    input  logic        RST,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [15:0] dout,
    output logic        empty,
    input  logic        rd_en,
    input  logic        mode_limit,
    input  logic        reg_output_limit,
    output logic [15:0] output_limit,
    output logic        output_limit_not_done,
    output logic        rd_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CW    = (ADDR_W + 1 > 16) ? ADDR_W + 1 : 16;

    localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [15:0]       r_ram [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_out_valid;
    logic [15:0]       r_dout;
    logic [15:0]       r_limit_left;
    logic [15:0]       r_output_limit;
    logic              r_not_done;
    logic              r_rd_err;

    logic              w_full;
    logic              w_fill;
    logic              w_pop;
    logic              w_load;
    logic              w_latch;
    logic              w_limit_zero;
    logic [ADDR_W:0]   w_ram_words;
    logic [CW-1:0]     w_count_ext;
    logic [15:0]       w_latch_val;
    logic [15:0]       w_limit_left_nxt;

    // count covers RAM plus the output register, so full blocks the fill side
    // even while the head word sits in the output register.
    assign w_full       = (r_count == FULL_COUNT);
    assign w_fill       = ~fifo_empty & ~w_full & ~RST;
    assign fifo_rd_en   = w_fill;

    assign w_limit_zero = (r_limit_left == 16'd0);
    assign empty        = ~r_out_valid | (mode_limit & w_limit_zero);
    assign w_pop        = rd_en & ~empty;
    assign w_latch      = reg_output_limit & mode_limit & w_limit_zero;

    assign w_ram_words  = r_count - {{ADDR_W{1'b0}}, r_out_valid};
    // Refill the output register whenever it is empty or being popped, giving
    // back-to-back words under continuous rd_en and a stable dout otherwise.
    assign w_load       = (~r_out_valid | w_pop) & (w_ram_words != '0);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_count_ext = CW'(r_count);
        w_latch_val = (w_count_ext > CW'(LIMIT_MAX)) ? LIMIT_MAX : w_count_ext[15:0];

        w_limit_left_nxt = r_limit_left;
        if (!mode_limit) begin
            w_limit_left_nxt = 16'd0;
        end else if (w_latch) begin
            w_limit_left_nxt = w_latch_val;
        end else if (w_pop) begin
            w_limit_left_nxt = r_limit_left - 16'd1;
        end
    end

    // NOTE: the RAM array has no reset; only pointers and count define its contents.
    always_ff @(posedge IFCLK) begin
        if (w_fill) begin
            r_ram[r_wr_ptr] <= fifo_dout;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge IFCLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_out_valid    <= 1'b0;
            r_dout         <= 16'd0;
            r_limit_left   <= 16'd0;
            r_output_limit <= 16'd0;
            r_not_done     <= 1'b0;
            r_rd_err       <= 1'b0;
        end else begin
            if (w_fill) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end

            case ({w_fill, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_load) begin
                r_dout      <= r_ram[r_rd_ptr];
                r_rd_ptr    <= r_rd_ptr + PTR_ONE;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end

            r_limit_left <= w_limit_left_nxt;
            r_not_done   <= (w_limit_left_nxt != 16'd0);

            if (w_latch) begin
                r_output_limit <= w_latch_val;
            end

            if (rd_en & empty) begin
                r_rd_err <= 1'b1;
            end
        end
    end

    assign dout                  = r_dout;
    assign output_limit          = r_output_limit;
    assign output_limit_not_done = r_not_done;
    assign rd_err                = r_rd_err;

endmodule

// File: tb/tb_output_limit_buffer.sv
// Bench for output_limit_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of buffered words and limit accounting.
module tb_output_limit_buffer;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic        IFCLK = 1'b0;
    logic        RST;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] dout;
    logic        empty;
    logic        rd_en;
    logic        mode_limit;
    logic        reg_output_limit;
    logic [15:0] output_limit;
    logic        output_limit_not_done;
    logic        rd_err;

    always #5 IFCLK = ~IFCLK;

    output_limit_buffer #(
        .ADDR_W   (ADDR_W),
        .LIMIT_MAX(16'hFFFF)
    ) dut (
        .IFCLK                (IFCLK),
        .RST                  (RST),
        .fifo_dout            (fifo_dout),
        .fifo_empty           (fifo_empty),
        .fifo_rd_en           (fifo_rd_en),
        .dout                 (dout),
        .empty                (empty),
        .rd_en                (rd_en),
        .mode_limit           (mode_limit),
        .reg_output_limit     (reg_output_limit),
        .output_limit         (output_limit),
        .output_limit_not_done(output_limit_not_done),
        .rd_err               (rd_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: upstream words, buffered words with their accept cycle,
    // and limit bookkeeping. A buffered head word is presentable two cycles after
    // it was accepted and no earlier than the cycle after its predecessor left.
    logic [15:0] up_q[$];
    logic [15:0] buf_q[$];
    int          buf_acc[$];
    int          cyc         = 0;
    int          last_pop    = -100;
    int          m_left      = 0;
    int          m_out_limit = 0;
    bit          m_rd_err    = 1'b0;

    function automatic bit m_visible();
        return buf_q.size() > 0 && cyc >= buf_acc[0] + 2 && cyc >= last_pop + 1;
    endfunction

    function automatic bit m_empty();
        return !m_visible() || (mode_limit && m_left == 0);
    endfunction

    function automatic bit m_fill();
        return !RST && up_q.size() > 0 && buf_q.size() < DEPTH;
    endfunction

    task automatic drive_up();
        fifo_empty = (up_q.size() == 0);
        fifo_dout  = (up_q.size() > 0) ? up_q[0] : 16'h0000;
    endtask

    task automatic model_reset();
        buf_q.delete();
        buf_acc.delete();
        last_pop    = -100;
        m_left      = 0;
        m_out_limit = 0;
        m_rd_err    = 1'b0;
    endtask

    task automatic tick();
        bit fill, pop, latch, err;
        fill  = m_fill();
        pop   = !RST && rd_en && !m_empty();
        err   = !RST && rd_en && m_empty();
        latch = !RST && reg_output_limit && mode_limit && m_left == 0;
        @(posedge IFCLK);
        if (RST) begin
            model_reset();
        end else begin
            if (!mode_limit) begin
                m_left = 0;
            end else if (latch) begin
                m_out_limit = (buf_q.size() > 65535) ? 65535 : buf_q.size();
                m_left      = m_out_limit;
            end else if (pop) begin
                m_left--;
            end
            if (pop) begin
                void'(buf_q.pop_front());
                void'(buf_acc.pop_front());
                last_pop = cyc;
            end
            if (fill) begin
                buf_q.push_back(up_q.pop_front());
                buf_acc.push_back(cyc);
            end
            if (err) m_rd_err = 1'b1;
        end
        cyc++;
        #1 drive_up();
    endtask

    task automatic test_reset();
        RST = 1'b1; rd_en = 1'b0; mode_limit = 1'b0; reg_output_limit = 1'b0;
        for (int v = 1; v <= 5; v++) up_q.push_back(16'(v));
        drive_up();
        model_reset();
        tick(); tick();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL rst_dout: got %h want 0000", dout); end
        checks++; if (output_limit !== 16'h0000) begin errors++; $display("FAIL rst_output_limit: got %h want 0000", output_limit); end
        checks++; if (output_limit_not_done !== 1'b0) begin errors++; $display("FAIL rst_not_done: got %b want 0", output_limit_not_done); end
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL rst_rd_err: got %b want 0", rd_err); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_fifo_rd_en: got %b want 0", fifo_rd_en); end
    endtask

    task automatic test_passthrough();
        RST = 1'b0;
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL pt_accept: got %b want 1", fifo_rd_en); end
        tick();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pt_empty_n1: got %b want 1", empty); end
        tick();
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (empty !== 1'b0) begin errors++; $display("FAIL pt_empty_word%0d: got %b want 0", i, empty); end
            checks++; if (dout !== 16'(i + 1)) begin errors++; $display("FAIL pt_dout_word%0d: got %h want %h", i, dout, 16'(i + 1)); end
            tick();
        end
        rd_en = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pt_empty_after: got %b want 1", empty); end
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL pt_rd_err: got %b want 0", rd_err); end
    endtask

    task automatic test_limit();
        mode_limit = 1'b1;
        for (int i = 0; i < 10; i++) up_q.push_back(16'h0100 + 16'(i));
        drive_up();
        repeat (13) tick();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lim_empty_unlatched: got %b want 1", empty); end
        reg_output_limit = 1'b1;
        tick();
        reg_output_limit = 1'b0;
        #1;
        checks++; if (output_limit !== 16'd10) begin errors++; $display("FAIL lim_output_limit: got %0d want 10", output_limit); end
        checks++; if (output_limit_not_done !== 1'b1) begin errors++; $display("FAIL lim_not_done_set: got %b want 1", output_limit_not_done); end
        for (int i = 0; i < 5; i++) up_q.push_back(16'h0200 + 16'(i));
        drive_up();
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (empty !== 1'b0 || dout !== 16'h0100 + 16'(i)) begin
                errors++; $display("FAIL lim_read%0d: got empty=%b dout=%h want empty=0 dout=%h", i, empty, dout, 16'h0100 + 16'(i));
            end
            tick();
        end
        rd_en = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lim_empty_after: got %b want 1", empty); end
        checks++; if (output_limit_not_done !== 1'b0) begin errors++; $display("FAIL lim_not_done_clr: got %b want 0", output_limit_not_done); end
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL lim_rd_err: got %b want 0", rd_err); end
    endtask

    task automatic test_limit_ignored();
        reg_output_limit = 1'b1;
        tick();
        reg_output_limit = 1'b0;
        #1;
        checks++; if (output_limit !== 16'd5) begin errors++; $display("FAIL ign_first_latch: got %0d want 5", output_limit); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) up_q.push_back(16'h0300 + 16'(i));
        drive_up();
        repeat (4) tick();
        reg_output_limit = 1'b1;
        tick();
        reg_output_limit = 1'b0;
        #1;
        checks++; if (output_limit !== 16'd5) begin errors++; $display("FAIL ign_limit_unchanged: got %0d want 5", output_limit); end
        checks++; if (output_limit_not_done !== 1'b1) begin errors++; $display("FAIL ign_not_done: got %b want 1", output_limit_not_done); end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (dout !== 16'h0201 + 16'(i)) begin errors++; $display("FAIL ign_read%0d: got %h want %h", i, dout, 16'h0201 + 16'(i)); end
            tick();
        end
        rd_en = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || output_limit_not_done !== 1'b0) begin
            errors++; $display("FAIL ign_exhausted: got empty=%b not_done=%b want 1/0", empty, output_limit_not_done);
        end
        reg_output_limit = 1'b1;
        tick();
        reg_output_limit = 1'b0;
        #1;
        checks++; if (output_limit !== 16'd3) begin errors++; $display("FAIL ign_second_latch: got %0d want 3", output_limit); end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (dout !== 16'h0300 + 16'(i)) begin errors++; $display("FAIL ign_drain%0d: got %h want %h", i, dout, 16'h0300 + 16'(i)); end
            tick();
        end
        rd_en = 1'b0;
        mode_limit = 1'b0;
        tick();
    endtask

    task automatic test_full_wrap();
        int n_acc;
        int bad;
        int k;
        RST = 1'b1;
        #1 model_reset();
        tick();
        RST = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) up_q.push_back(16'($urandom));
        drive_up();
        n_acc = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            #1;
            if (fifo_rd_en) n_acc++;
            tick();
        end
        checks++; if (n_acc !== DEPTH) begin errors++; $display("FAIL full_accepts: got %0d want %0d", n_acc, DEPTH); end
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL full_rd_en_low: got %b want 0", fifo_rd_en); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (fifo_rd_en) n_acc++;
            tick();
        end
        checks++; if (n_acc !== 1) begin errors++; $display("FAIL full_readmit: got %0d want 1", n_acc); end
        rd_en = 1'b1;
        bad = 0;
        k = 0;
        while (buf_q.size() > 0 && k < DEPTH + 50) begin
            #1;
            if (empty !== m_empty()) bad++;
            else if (!m_empty() && dout !== buf_q[0]) bad++;
            tick();
            k++;
        end
        rd_en = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_data: got %0d bad cycles want 0", bad); end
        checks++; if (k >= DEPTH + 50) begin errors++; $display("FAIL wrap_drain_timeout: got %0d cycles want < %0d", k, DEPTH + 50); end
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty_end: got %b want 1", empty); end
    endtask

    task automatic test_same_cycle_latch();
        RST = 1'b1;
        #1 model_reset();
        tick();
        RST = 1'b0;
        mode_limit = 1'b1;
        for (int i = 0; i < 4; i++) up_q.push_back(16'h0400 + 16'(i));
        drive_up();
        tick(); tick(); tick();
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL sc_accept_in_latch_cycle: got %b want 1", fifo_rd_en); end
        reg_output_limit = 1'b1;
        tick();
        reg_output_limit = 1'b0;
        #1;
        checks++; if (output_limit !== 16'd3) begin errors++; $display("FAIL sc_output_limit: got %0d want 3", output_limit); end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (dout !== 16'h0400 + 16'(i)) begin errors++; $display("FAIL sc_read%0d: got %h want %h", i, dout, 16'h0400 + 16'(i)); end
            tick();
        end
        rd_en = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || rd_err !== 1'b0) begin
            errors++; $display("FAIL sc_before_err: got empty=%b rd_err=%b want 1/0", empty, rd_err);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        #1;
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL sc_rd_err_set: got %b want 1", rd_err); end
        repeat (3) tick();
        #1;
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL sc_rd_err_sticky: got %b want 1", rd_err); end
        reg_output_limit = 1'b1;
        tick();
        reg_output_limit = 1'b0;
        #1;
        checks++; if (output_limit !== 16'd1) begin errors++; $display("FAIL sc_word_kept: got limit %0d want 1", output_limit); end
        rd_en = 1'b1;
        #1;
        checks++; if (dout !== 16'h0403) begin errors++; $display("FAIL sc_last_word: got %h want 0403", dout); end
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int k;
        mode_limit = 1'b0;
        for (int i = 0; i < 100; i++) up_q.push_back(16'h1000 + 16'(i));
        drive_up();
        repeat (105) tick();
        #1;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL mr_buffered: got empty=%b want 0", empty); end
        RST = 1'b1;
        #1;
        checks++; if (empty !== 1'b1 || dout !== 16'h0000) begin
            errors++; $display("FAIL mr_async_out: got empty=%b dout=%h want 1/0000", empty, dout);
        end
        checks++; if (output_limit !== 16'h0000 || output_limit_not_done !== 1'b0 || rd_err !== 1'b0) begin
            errors++; $display("FAIL mr_async_regs: got limit=%h not_done=%b rd_err=%b want 0000/0/0", output_limit, output_limit_not_done, rd_err);
        end
        model_reset();
        up_q.push_back(16'hBEEF);
        drive_up();
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mr_rd_en_in_reset: got %b want 0", fifo_rd_en); end
        tick();
        RST = 1'b0;
        k = 0;
        #1;
        while (empty && k < 10) begin
            tick();
            #1;
            k++;
        end
        checks++; if (empty !== 1'b0 || dout !== 16'hBEEF) begin
            errors++; $display("FAIL mr_first_after_reset: got empty=%b dout=%h want 0/beef", empty, dout);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 2) mode_limit = ~mode_limit;
            rd_en            = ($urandom_range(0, 99) < 60);
            reg_output_limit = ($urandom_range(0, 99) < 8);
            if (up_q.size() < 4 && $urandom_range(0, 99) < 50) begin
                n = $urandom_range(1, 12);
                for (int i = 0; i < n; i++) up_q.push_back(16'($urandom));
                drive_up();
            end
            #1;
            checks++; if (empty !== m_empty()) begin errors++; $display("FAIL rnd_empty c%0d: got %b want %b", c, empty, m_empty()); end
            checks++; if (fifo_rd_en !== m_fill()) begin errors++; $display("FAIL rnd_fifo_rd_en c%0d: got %b want %b", c, fifo_rd_en, m_fill()); end
            checks++; if (output_limit !== 16'(m_out_limit)) begin errors++; $display("FAIL rnd_output_limit c%0d: got %0d want %0d", c, output_limit, m_out_limit); end
            checks++; if (output_limit_not_done !== (m_left != 0)) begin errors++; $display("FAIL rnd_not_done c%0d: got %b want %b", c, output_limit_not_done, m_left != 0); end
            checks++; if (rd_err !== m_rd_err) begin errors++; $display("FAIL rnd_rd_err c%0d: got %b want %b", c, rd_err, m_rd_err); end
            if (!m_empty()) begin
                checks++; if (dout !== buf_q[0]) begin errors++; $display("FAIL rnd_dout c%0d: got %h want %h", c, dout, buf_q[0]); end
            end
            tick();
        end
        rd_en = 1'b0;
        reg_output_limit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_limit();
        test_limit_ignored();
        test_full_wrap();
        test_same_cycle_latch();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
